bram_arbiter: RTL and testbench
===============================

Name: bram_arbiter

Overview:
- Shares one single-port synchronous BRAM (1-cycle read latency, write-then-read-old semantics) between two requesters: port A (serial SPI front end) and port B (parallel host/debug logic).
- Arbitrates per access with round-robin, registers the winning command onto the memory port and returns read data with a valid strobe to the winner.
- Sits between the requesters and the `mybram` instance; it is the only driver of the BRAM's addr/din/we.

Parameters:
- LOGSIZE, 5, address width; memory depth is 2**LOGSIZE words.
- WIDTH, 16, data word width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- a_req  in  1  port A access request; held high until a_gnt is seen.
- a_we  in  1  port A access type: 1 = write, 0 = read; stable while a_req is high.
- a_addr  in  LOGSIZE  port A word address.
- a_wdata  in  WIDTH  port A write data.
- a_gnt  out  1  one-cycle pulse: port A command has been issued to memory.
- a_rvalid  out  1  one-cycle pulse: a_rdata holds port A read result.
- a_rdata  out  WIDTH  port A read data; valid only while a_rvalid is high.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- mem_addr  out  LOGSIZE  registered BRAM address.
- mem_din  out  WIDTH  registered BRAM write data.
- mem_we  out  1  registered BRAM write enable.
- mem_dout  in  WIDTH  BRAM read data, valid the cycle after the read is issued.

Behaviour:
- Reset (async, active-high):
  - gnt, rvalid, mem_we and mem_addr/mem_din clear to 0.
  - Read pipeline is flushed; no rvalid is emitted for a read that was in flight when rst asserted.
  - Round-robin pointer `last` resets to B, so A wins the first tie.
- Eligibility:
  - x is eligible in cycle t if x_req=1 and x_gnt=0 in cycle t.
  - A requester whose grant pulse is currently high is ignored, so it cannot be granted twice for one request.
  - A requester drops req (or presents a new command) in the cycle after gnt.
- Arbitration, evaluated in cycle t and registered at the edge ending t:
  - Neither eligible: mem_we=0, both gnt=0, mem_addr/mem_din hold their previous values.
  - One eligible: it wins.
  - Both eligible: the port not equal to `last` wins.
  - `last` updates only on a grant.
- Issue, cycle t+1:
  - x_gnt=1 for exactly one cycle.
  - mem_addr = x_addr, mem_din = x_wdata, mem_we = x_we (all sampled in cycle t).
  - mem_we is high for exactly one cycle per write grant.
- Read return:
  - For a read granted with gnt in cycle t+1, x_rvalid=1 in cycle t+2, with x_rdata = mem_dout.
  - The issuing port is tracked in a 1-deep owner register.
  - The other port's rvalid stays 0.
  - rdata is registered-through from mem_dout (combinational pass, gated to 0 when rvalid=0).
- Write completion: completion is the gnt pulse; a write produces no rvalid.
- Throughput:
  - One memory access per cycle in aggregate.
  - One access per 2 cycles per port when both ports request continuously; strict alternation A,B,A,B.
- Hazards:
  - A read issued the cycle after a write to the same address returns the new data; BRAM ordering preserves this naturally and the arbiter does not reorder.
  - A read issued in the same cycle as a write is impossible (one command per cycle).
- Reset mid-operation: a requester must reissue any request that had not received gnt before rst.
- FSM: no explicit states beyond the `last` pointer, the issue register and the 1-deep read-owner/valid pipeline. Implementer may encode these as IDLE / ISSUE_A / ISSUE_B; transitions are as above.

Optional Feature:
- BRAM_ARB_FIXED_PRIO_EN defined:
  - Port A always wins ties; `last` is unused.
  - Port B is granted only in cycles where A is not eligible.
- Undefined: round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
- Reset with a_req=1 held asserted → all outputs 0 during rst. First cycle after release: arbitrate. Next cycle: a_gnt=1 and mem_addr=a_addr.
- A writes addr 5 = 16'hBEEF, then reads addr 5:
  - mem_we=1 exactly one cycle.
  - a_rvalid=1 two cycles after the read request cycle, with a_rdata=16'hBEEF.
  - b_rvalid stays 0.
- A and B both request continuously (A reads addr 1, B reads addr 2; memory preloaded 16'h0001/16'h0002) → grants alternate A,B,A,B. a_rdata=16'h0001 and b_rdata=16'h0002 each with a single rvalid pulse.
- B writes addr 31 = 16'hFFFF while A is idle → b_gnt=1 in cycle 2 and mem_addr=31. A later read of addr 31 by A returns 16'hFFFF (address wrap: no aliasing to 0).
- Assert rst in the cycle between a read's gnt and its rvalid → a_rvalid never pulses for that read. Reissued read returns correct data.
- BRAM_ARB_FIXED_PRIO_EN build, both requesting continuously → A granted every second cycle (each cycle it is eligible). B is granted only in the cycles where a_gnt is high.

Source files
------------

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between requesters A and B.
// Define BRAM_ARB_FIXED_PRIO_EN to give port A fixed priority instead of round-robin.
module bram_arbiter #(
  parameter int LOGSIZE = 5,
  parameter int WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_req,
  input  logic               a_we,
  input  logic [LOGSIZE-1:0] a_addr,
  input  logic [WIDTH-1:0]   a_wdata,
  output logic               a_gnt,
  output logic               a_rvalid,
  output logic [WIDTH-1:0]   a_rdata,
  input  logic               b_req,
  input  logic               b_we,
  input  logic [LOGSIZE-1:0] b_addr,
  input  logic [WIDTH-1:0]   b_wdata,
  output logic               b_gnt,
  output logic               b_rvalid,
  output logic [WIDTH-1:0]   b_rdata,
  output logic [LOGSIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]   mem_din,
  output logic               mem_we,
  input  logic [WIDTH-1:0]   mem_dout
);

  // Owner of the read currently presented to the BRAM (data returns next cycle).
  typedef enum logic [1:0] {RD_IDLE, RD_A, RD_B} rd_state_t;

  rd_state_t rd_state;
  logic      a_elig;
  logic      b_elig;
  logic      a_win;
  logic      b_win;
`ifndef BRAM_ARB_FIXED_PRIO_EN
  logic      last;
`endif

  // A port whose grant pulse is high is still holding its old request, so it is skipped.
  always_comb begin
    a_elig = a_req & ~a_gnt;
    b_elig = b_req & ~b_gnt;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    a_win  = a_elig;
    b_win  = b_elig & ~a_elig;
`else
    a_win  = a_elig & (~b_elig | last);
    b_win  = b_elig & (~a_elig | ~last);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
      rd_state <= RD_IDLE;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
`ifndef BRAM_ARB_FIXED_PRIO_EN
      last     <= 1'b1;
`endif
    end else begin
      a_gnt  <= a_win;
      b_gnt  <= b_win;
      mem_we <= (a_win & a_we) | (b_win & b_we);
      if (a_win) begin
        mem_addr <= a_addr;
        mem_din  <= a_wdata;
      end else if (b_win) begin
        mem_addr <= b_addr;
        mem_din  <= b_wdata;
      end
`ifndef BRAM_ARB_FIXED_PRIO_EN
      if (a_win)
        last <= 1'b0;
      else if (b_win)
        last <= 1'b1;
`endif
      if (a_win && !a_we)
        rd_state <= RD_A;
      else if (b_win && !b_we)
        rd_state <= RD_B;
      else
        rd_state <= RD_IDLE;
      a_rvalid <= (rd_state == RD_A);
      b_rvalid <= (rd_state == RD_B);
    end
  end

  assign a_rdata = a_rvalid ? mem_dout : '0;
  assign b_rdata = b_rvalid ? mem_dout : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Self-checking bench for bram_arbiter with a behavioural write-then-read-old BRAM.
// Expectations follow the BRAM_ARB_FIXED_PRIO_EN build when that macro is defined.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [4:0]  a_addr, b_addr, mem_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_din, mem_dout;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [0:31] = '{1: 16'h0001, 2: 16'h0002, default: 16'h0000};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  bram_arbiter #(.LOGSIZE(5), .WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  typedef struct {
    logic        a_req, a_we;
    logic [4:0]  a_addr;
    logic [15:0] a_wdata;
    logic        b_req, b_we;
    logic [4:0]  b_addr;
    logic [15:0] b_wdata;
    logic        e_agnt, e_bgnt, e_we;
    logic [4:0]  e_addr;
    logic [15:0] e_din;
    logic        e_arv, e_brv;
    logic [15:0] e_ard, e_brd;
  } vec_t;

  vec_t vecs [0:14];

  function automatic vec_t mk(input logic ar, aw, input logic [4:0] aa, input logic [15:0] ad,
                              input logic br, bw, input logic [4:0] ba, input logic [15:0] bd,
                              input logic ga, gb, we, input logic [4:0] ea, input logic [15:0] ed,
                              input logic rva, rvb, input logic [15:0] rda, rdb);
    vec_t v;
    v.a_req = ar; v.a_we = aw; v.a_addr = aa; v.a_wdata = ad;
    v.b_req = br; v.b_we = bw; v.b_addr = ba; v.b_wdata = bd;
    v.e_agnt = ga; v.e_bgnt = gb; v.e_we = we; v.e_addr = ea; v.e_din = ed;
    v.e_arv = rva; v.e_brv = rvb; v.e_ard = rda; v.e_brd = rdb;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ar, aw, input logic [4:0] aa, input logic [15:0] ad,
                               input logic br, bw, input logic [4:0] ba, input logic [15:0] bd);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic first_b, win_b, prev_b;
`ifdef BRAM_ARB_FIXED_PRIO_EN
    first_b = 1'b0;
`else
    first_b = 1'b1;
`endif

    // Reset with A holding a read request of address 7.
    rst = 1'b1;
    applyStimulus(1, 0, 5'd7, 16'h0, 0, 0, 5'd0, 16'h0);
    step(); step();
    checkOutput("reset_outputs",
                {a_gnt, b_gnt, mem_we, mem_addr, mem_din, a_rvalid, b_rvalid, a_rdata, b_rdata},
                '0);
    rst = 1'b0;
    step();
    checkOutput("post_reset_gnt", {a_gnt, b_gnt, mem_addr}, {1'b1, 1'b0, 5'd7});
    a_req = 1'b0;
    step();
    checkOutput("post_reset_rvalid", {a_gnt, a_rvalid, b_rvalid, a_rdata}, {1'b0, 1'b1, 1'b0, 16'h0});
    step();
    checkOutput("post_reset_idle", {a_rvalid, b_rvalid}, 2'b00);

    vecs[0]  = mk(1,1,5'd5,16'hBEEF, 0,0,5'd0,16'h0,    1,0,1,5'd5,16'hBEEF, 0,0,16'h0,16'h0);
    vecs[1]  = mk(0,0,5'd0,16'h0,    0,0,5'd0,16'h0,    0,0,0,5'd5,16'h0,    0,0,16'h0,16'h0);
    vecs[2]  = mk(1,0,5'd5,16'h0,    0,0,5'd0,16'h0,    1,0,0,5'd5,16'h0,    0,0,16'h0,16'h0);
    vecs[3]  = mk(0,0,5'd0,16'h0,    0,0,5'd0,16'h0,    0,0,0,5'd5,16'h0,    1,0,16'hBEEF,16'h0);
    vecs[4]  = mk(0,0,5'd0,16'h0,    1,1,5'd31,16'hFFFF, 0,1,1,5'd31,16'hFFFF, 0,0,16'h0,16'h0);
    vecs[5]  = mk(0,0,5'd0,16'h0,    0,0,5'd0,16'h0,    0,0,0,5'd31,16'h0,   0,0,16'h0,16'h0);
    vecs[6]  = mk(1,0,5'd1,16'h0,    1,0,5'd2,16'h0,    1,0,0,5'd1,16'h0,    0,0,16'h0,16'h0);
    vecs[7]  = mk(1,0,5'd1,16'h0,    1,0,5'd2,16'h0,    0,1,0,5'd2,16'h0,    1,0,16'h0001,16'h0);
    vecs[8]  = mk(1,0,5'd1,16'h0,    1,0,5'd2,16'h0,    1,0,0,5'd1,16'h0,    0,1,16'h0,16'h0002);
    vecs[9]  = mk(0,0,5'd0,16'h0,    0,0,5'd0,16'h0,    0,0,0,5'd1,16'h0,    1,0,16'h0001,16'h0);
    vecs[10] = mk(0,0,5'd0,16'h0,    0,0,5'd0,16'h0,    0,0,0,5'd1,16'h0,    0,0,16'h0,16'h0);
    vecs[11] = mk(1,0,5'd31,16'h0,   0,0,5'd0,16'h0,    1,0,0,5'd31,16'h0,   0,0,16'h0,16'h0);
    vecs[12] = mk(0,0,5'd0,16'h0,    0,0,5'd0,16'h0,    0,0,0,5'd31,16'h0,   1,0,16'hFFFF,16'h0);
    vecs[13] = mk(1,0,5'd0,16'h0,    0,0,5'd0,16'h0,    1,0,0,5'd0,16'h0,    0,0,16'h0,16'h0);
    vecs[14] = mk(0,0,5'd0,16'h0,    0,0,5'd0,16'h0,    0,0,0,5'd0,16'h0,    1,0,16'h0,16'h0);

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].a_req, vecs[i].a_we, vecs[i].a_addr, vecs[i].a_wdata,
                    vecs[i].b_req, vecs[i].b_we, vecs[i].b_addr, vecs[i].b_wdata);
      step();
      checkOutput($sformatf("vec%0d", i),
                  {a_gnt, b_gnt, mem_we, mem_addr, a_rvalid, b_rvalid, a_rdata, b_rdata},
                  {vecs[i].e_agnt, vecs[i].e_bgnt, vecs[i].e_we, vecs[i].e_addr,
                   vecs[i].e_arv, vecs[i].e_brv, vecs[i].e_ard, vecs[i].e_brd});
      if (vecs[i].e_we)
        checkOutput($sformatf("vec%0d_din", i), mem_din, vecs[i].e_din);
    end

    // Continuous contention with last grant to A: round-robin starts with B.
    applyStimulus(1, 0, 5'd1, 16'h0, 1, 0, 5'd2, 16'h0);
    for (int k = 0; k < 8; k++) begin
      step();
      win_b = first_b ^ k[0];
      checkOutput($sformatf("alt%0d_gnt", k), {a_gnt, b_gnt}, {~win_b, win_b});
      if (k == 0) begin
        checkOutput("alt0_rvalid", {a_rvalid, b_rvalid}, 2'b00);
      end else begin
        prev_b = ~win_b;
        checkOutput($sformatf("alt%0d_rd", k), {a_rvalid, b_rvalid, a_rdata, b_rdata},
                    {~prev_b, prev_b, prev_b ? 16'h0 : 16'h0001, prev_b ? 16'h0002 : 16'h0});
      end
    end
    applyStimulus(0, 0, 5'd0, 16'h0, 0, 0, 5'd0, 16'h0);
    step();
    prev_b = ~first_b;
    checkOutput("alt_tail", {a_gnt, b_gnt, a_rvalid, b_rvalid}, {2'b00, ~prev_b, prev_b});
    step();
    checkOutput("alt_quiet", {a_rvalid, b_rvalid}, 2'b00);

    // Reset between a read's grant and its data return.
    applyStimulus(1, 0, 5'd5, 16'h0, 0, 0, 5'd0, 16'h0);
    step();
    checkOutput("midrst_gnt", {a_gnt, mem_addr}, {1'b1, 5'd5});
    a_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_clear", {a_gnt, mem_we, mem_addr, a_rvalid, a_rdata}, '0);
    step();
    rst = 1'b0;
    step();
    checkOutput("midrst_no_rvalid1", {a_rvalid, b_rvalid}, 2'b00);
    step();
    checkOutput("midrst_no_rvalid2", {a_rvalid, b_rvalid}, 2'b00);
    a_req = 1'b1;
    step();
    checkOutput("reissue_gnt", {a_gnt, b_gnt, mem_addr}, {2'b10, 5'd5});
    a_req = 1'b0;
    step();
    checkOutput("reissue_rd", {a_rvalid, b_rvalid, a_rdata}, {2'b10, 16'hBEEF});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
